mux_scan_driver: RTL

//  Upstream driver for mux_4x1_n: holds four BITS-wide operands (Q3..Q0 -> mux D3..D0) and

---
 rtl/mux_scan_pkg.sv | 14 +
 rtl/mux_scan_driver_tick_divider.sv | 37 +++
 rtl/mux_scan_driver.sv | 86 ++++++++
 3 files changed

// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared constants and helpers for the mux_scan_driver block
//   ST_IDLE / ST_SCAN : scan FSM state encoding
//   N_SLOTS           : number of multiplexed display slots
//   ANODE_OFF         : all anodes deasserted (active-low)
//   slot_anode()      : one-hot active-low anode pattern for a slot index
package mux_scan_pkg;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_SCAN = 1'b1;
  localparam int N_SLOTS = 4;
  localparam logic [3:0] ANODE_OFF = 4'b1111;
  function automatic logic [3:0] slot_anode(input logic [1:0] sel);
    return ~(4'b0001 << sel);
  endfunction
endpackage

// File: rtl/mux_scan_driver_tick_divider.sv
// tick_divider: slot prescaler counting 0..DIV-1 with a tick on the last count
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset
//   en_i     : count enable
//   clr_i    : synchronous clear to 0 (wins over en_i)
//   tick_o   : high while the count is DIV-1
//   blank_o  : high during the first BLANK counts of a slot when MUX_SCAN_BLANKING_EN
//              is defined, constant 0 otherwise
module tick_divider #(
  parameter int DIV = 4,
  parameter int BLANK = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o,
  output logic blank_o
);
  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  if (DIV < 2 || BLANK < 0 || BLANK >= DIV) begin : g_bad_cfg
    $error("tick_divider: need DIV >= 2 and 0 <= BLANK < DIV");
  end
  logic [CW-1:0] cnt_q, cnt_d;
  assign tick_o = cnt_q == LAST;
`ifdef MUX_SCAN_BLANKING_EN
  assign blank_o = cnt_q < CW'(BLANK);
`else
  assign blank_o = 1'b0;
`endif
  always_comb cnt_d = clr_i ? '0 : !en_i ? cnt_q : tick_o ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mux_scan_driver.sv
// mux_scan_driver: round-robin SEL/ANODE scan driver with frame-synchronous operand commit
//   clk_i          : clock, rising edge
//   rst_ni         : asynchronous active-low reset
//   enable_i       : 1 = scan running, 0 = idle
//   load_i         : strobe capturing data_i into the shadow register
//   data_i         : {op3, op2, op1, op0}
//   q3_o..q0_o     : committed operands for mux D3..D0
//   sel_o          : current slot index
//   anode_o        : active-low one-hot slot enable
//   pending_o      : shadow holds data not yet committed
//   frame_done_o   : one-cycle pulse as the slot wraps 3 -> 0
// Optional feature: define MUX_SCAN_BLANKING_EN to blank anode_o for the first BLANK
// cycles of every slot.
module mux_scan_driver
  import mux_scan_pkg::*;
#(
  parameter int BITS = 4,
  parameter int DIV = 4,
  parameter int BLANK = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic              load_i,
  input  logic [4*BITS-1:0] data_i,
  output logic [BITS-1:0]   q3_o,
  output logic [BITS-1:0]   q2_o,
  output logic [BITS-1:0]   q1_o,
  output logic [BITS-1:0]   q0_o,
  output logic [1:0]        sel_o,
  output logic [3:0]        anode_o,
  output logic              pending_o,
  output logic              frame_done_o
);
  localparam logic [1:0] LAST_SLOT = 2'(N_SLOTS - 1);
  logic state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [4*BITS-1:0] shadow_q, shadow_d, q_q, q_d;
  logic pending_q, pending_d, fd_q, fd_d;
  logic tick, blank, run, wrap, commit;
  // run: scanning this cycle and staying in SCAN across the next edge
  assign run = state_q == ST_SCAN && enable_i;
  assign wrap = run && tick && sel_q == LAST_SLOT;
  // Idle displays nothing, so commits are safe on any edge there
  assign commit = pending_q && (wrap || state_q == ST_IDLE);
  tick_divider #(.DIV(DIV), .BLANK(BLANK)) u_div (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (run),
    .clr_i   (!run),
    .tick_o  (tick),
    .blank_o (blank)
  );
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else state_q <= state_d;
  end
  always_comb state_d = enable_i ? ST_SCAN : ST_IDLE;
  always_comb anode_o = (state_q == ST_SCAN && !blank) ? slot_anode(sel_q) : ANODE_OFF;
  always_comb begin
    sel_d = run ? (tick ? sel_q + 2'd1 : sel_q) : 2'd0;
    q_d = commit ? shadow_q : q_q;
    shadow_d = load_i ? data_i : shadow_q;
    pending_d = load_i || (pending_q && !commit);
    fd_d = wrap;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_q <= '0;
      q_q <= '0;
      shadow_q <= '0;
      pending_q <= 1'b0;
      fd_q <= 1'b0;
    end else begin
      sel_q <= sel_d;
      q_q <= q_d;
      shadow_q <= shadow_d;
      pending_q <= pending_d;
      fd_q <= fd_d;
    end
  end
  assign {q3_o, q2_o, q1_o, q0_o} = q_q;
  assign sel_o = sel_q;
  assign pending_o = pending_q;
  assign frame_done_o = fd_q;
endmodule
